// File: rtl/burst_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram_if
//  Description : Bundle of the burst_ram address, write-beat and read-beat
//                signals.
//                slave  modport : the RAM side (burst_ram)
//                master modport : the initiator side
//                Write address : awaddr, awlen, awvalid -> awready
//                Write beats   : wvalid, wlast -> initiator; wdata, wready <-
//                Read address  : araddr, arlen, arvalid -> arready
//                Read beats    : rdata, rvalid, rlast -> initiator; rready <-
//  Revision    : 1.0  initial release
// ============================================================================
interface burst_ram_if #(
   parameter int AWIDTH = 32,
   parameter int LWIDTH = 8,
   parameter int DWIDTH = 32
);
   logic [AWIDTH-1:0] awaddr;
   logic [LWIDTH-1:0] awlen;
   logic              awvalid;
   logic              awready;
   logic              wvalid;
   logic              wlast;
   logic [DWIDTH-1:0] wdata;
   logic              wready;
   logic [AWIDTH-1:0] araddr;
   logic [LWIDTH-1:0] arlen;
   logic              arvalid;
   logic              arready;
   logic [DWIDTH-1:0] rdata;
   logic              rvalid;
   logic              rlast;
   logic              rready;

   modport slave (
      input  awaddr, awlen, awvalid, wdata, wready, araddr, arlen, arvalid, rready,
      output awready, wvalid, wlast, arready, rdata, rvalid, rlast
   );

   modport master (
      output awaddr, awlen, awvalid, wdata, wready, araddr, arlen, arvalid, rready,
      input  awready, wvalid, wlast, arready, rdata, rvalid, rlast
   );
endinterface
`default_nettype wire

// File: rtl/burst_ram.sv
`default_nettype none
// ============================================================================
//  Module      : burst_ram
//  Description : Word-addressed RAM with a burst write port and a burst read
//                port sharing one controller; one burst in flight at a time.
//                Write wins when both requests arrive together. The RAM
//                pulls write beats with wvalid; the initiator answers with
//                wdata one cycle later. All outputs are registered.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - burst_ram_if.slave (address, write and read channels)
//  Revision    : 1.0  initial release
// ============================================================================
module burst_ram #(
   parameter int AWIDTH = 32,
   parameter int LWIDTH = 8,
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 4096
) (
   input  wire logic    clk,
   input  wire logic    rst,
   burst_ram_if.slave   bus
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WBEAT  = 2'd1,
      WDRAIN = 2'd2,
      RBEAT  = 2'd3
   } state_t;

   // Storage carries no reset so contents survive rst.
   logic [DWIDTH-1:0] mem [DEPTH];

   state_t            state_q, state_nx;
   logic [IW-1:0]     base_q, base_nx;
   logic [LWIDTH-1:0] last_q, last_nx;
   logic [LWIDTH-1:0] cnt_q, cnt_nx;
   logic              awready_q, awready_nx;
   logic              arready_q, arready_nx;
   logic              wvalid_q, wvalid_nx;
   logic              wlast_q, wlast_nx;
   logic [IW-1:0]     w_word_q, w_word_nx;
   logic              rvalid_q, rvalid_nx;
   logic              rlast_q, rlast_nx;
   logic [DWIDTH-1:0] rdata_q, rdata_nx;
   logic              cap_en_q;
   logic [IW-1:0]     cap_word_q;

   logic [IW-1:0]     cur_word;
   logic [IW-1:0]     nxt_word;
   logic [LWIDTH-1:0] cnt_inc;

   // Byte-offset and upper address bits carry no meaning for word indexing.
   logic [AWIDTH-1:0] unused_addr;
   assign unused_addr = bus.awaddr ^ bus.araddr;

   // Index of the final beat; a zero length still moves one beat.
   function automatic logic [LWIDTH-1:0] last_index(input logic [LWIDTH-1:0] len);
      return (len == '0) ? '0 : len - LWIDTH'(1);
   endfunction

   assign cur_word = base_q + IW'(cnt_q);
   assign nxt_word = cur_word + IW'(1);
   assign cnt_inc  = cnt_q + LWIDTH'(1);

   always_comb begin
      state_nx   = state_q;
      base_nx    = base_q;
      last_nx    = last_q;
      cnt_nx     = cnt_q;
      awready_nx = 1'b0;
      arready_nx = 1'b0;
      wvalid_nx  = 1'b0;
      wlast_nx   = 1'b0;
      w_word_nx  = w_word_q;
      rvalid_nx  = rvalid_q;
      rlast_nx   = rlast_q;
      rdata_nx   = rdata_q;

      case (state_q)
         IDLE: begin
            if (bus.awvalid) begin
               base_nx    = bus.awaddr[2 +: IW];
               last_nx    = last_index(bus.awlen);
               cnt_nx     = '0;
               awready_nx = 1'b1;
               state_nx   = WBEAT;
            end else if (bus.arvalid) begin
               base_nx    = bus.araddr[2 +: IW];
               last_nx    = last_index(bus.arlen);
               cnt_nx     = '0;
               arready_nx = 1'b1;
               state_nx   = RBEAT;
            end
         end

         WBEAT: begin
            // Once the final beat is on the wire, stop requesting and wait
            // one cycle for its data.
            if (wlast_q) begin
               state_nx = WDRAIN;
            end else if (bus.wready) begin
               wvalid_nx = 1'b1;
               wlast_nx  = (cnt_q == last_q);
               w_word_nx = cur_word;
               cnt_nx    = cnt_inc;
            end
         end

         WDRAIN: begin
            state_nx = IDLE;
         end

         RBEAT: begin
            if (!rvalid_q) begin
               // First beat, presented the cycle after arready.
               rvalid_nx = 1'b1;
               rdata_nx  = mem[cur_word];
               rlast_nx  = (cnt_q == last_q);
            end else if (bus.rready) begin
               if (rlast_q) begin
                  rvalid_nx = 1'b0;
                  rlast_nx  = 1'b0;
                  state_nx  = IDLE;
               end else begin
                  cnt_nx   = cnt_inc;
                  rdata_nx = mem[nxt_word];
                  rlast_nx = (cnt_inc == last_q);
               end
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         last_q     <= '0;
         cnt_q      <= '0;
         awready_q  <= 1'b0;
         arready_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wlast_q    <= 1'b0;
         w_word_q   <= '0;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rdata_q    <= '0;
         cap_en_q   <= 1'b0;
         cap_word_q <= '0;
      end else begin
         state_q    <= state_nx;
         base_q     <= base_nx;
         last_q     <= last_nx;
         cnt_q      <= cnt_nx;
         awready_q  <= awready_nx;
         arready_q  <= arready_nx;
         wvalid_q   <= wvalid_nx;
         wlast_q    <= wlast_nx;
         w_word_q   <= w_word_nx;
         rvalid_q   <= rvalid_nx;
         rlast_q    <= rlast_nx;
         rdata_q    <= rdata_nx;
         // A beat requested this cycle has its data on wdata next cycle.
         cap_en_q   <= wvalid_q;
         cap_word_q <= w_word_q;
      end
   end

   // Not gated by rst: a capture already due on the reset edge still lands,
   // while the reset clears cap_en_q so any later pending capture is dropped.
   always_ff @(posedge clk) begin
      if (cap_en_q) begin
         mem[cap_word_q] <= bus.wdata;
      end
   end

   assign bus.awready = awready_q;
   assign bus.arready = arready_q;
   assign bus.wvalid  = wvalid_q;
   assign bus.wlast   = wlast_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rlast   = rlast_q;
   assign bus.rdata   = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_burst_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_ram
//  Description : Self-checking bench for burst_ram. A shadow word array is
//                updated as write data is driven; read bursts push expected
//                words into a queue that is popped as beats are consumed.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_ram;
   localparam int AWIDTH = 32;
   localparam int LWIDTH = 8;
   localparam int DWIDTH = 32;
   localparam int DEPTH  = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   burst_ram_if #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH), .DWIDTH(DWIDTH)) bus ();

   burst_ram #(
      .AWIDTH(AWIDTH),
      .LWIDTH(LWIDTH),
      .DWIDTH(DWIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [DWIDTH-1:0] model [DEPTH];
   logic [DWIDTH-1:0] exp_q [$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic int widx(input logic [31:0] addr, input int k);
      return ((addr >> 2) + k) % DEPTH;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_awready"}, bus.awready, 0);
      check_eq({tag, "_arready"}, bus.arready, 0);
      check_eq({tag, "_wvalid"},  bus.wvalid,  0);
      check_eq({tag, "_wlast"},   bus.wlast,   0);
      check_eq({tag, "_rvalid"},  bus.rvalid,  0);
      check_eq({tag, "_rlast"},   bus.rlast,   0);
      check_eq({tag, "_rdata"},   bus.rdata,   0);
   endtask

   // Beat k carries seed + k*0x11. rst_beat >= 0 asserts rst in the cycle
   // that beat's wvalid is seen.
   task automatic do_write(input logic [31:0] addr, input int len, input logic [31:0] seed,
                           input int stall_beat, input int stall_len, input int rst_beat);
      int n = (len == 0) ? 1 : len;
      int seen = 0, driven = 0, aw_pulses = 0, ar_pulses = 0, cyc = 0;
      int stall_left = stall_len, pk = 0;
      bit pend = 0, aborted = 0;
      bus.awaddr  = addr;
      bus.awlen   = LWIDTH'(len);
      bus.awvalid = 1'b1;
      bus.wready  = 1'b1;
      while (driven < n && !aborted && cyc < 100) begin
         @(posedge clk); #1; cyc++;
         if (bus.awready) begin aw_pulses++; bus.awvalid = 1'b0; end
         if (bus.arready) ar_pulses++;
         if (pend) begin
            bus.wdata = seed + pk * 32'h11;
            model[widx(addr, pk)] = bus.wdata;
            driven++;
            pend = 0;
         end
         if (bus.wvalid) begin
            check_eq("wlast", bus.wlast, seen == n - 1);
            pend = 1; pk = seen;
            if (seen == rst_beat) begin rst = 1'b1; aborted = 1; end
            seen++;
         end
         if (seen == stall_beat && stall_left > 0) begin
            bus.wready = 1'b0; stall_left--;
         end else begin
            bus.wready = 1'b1;
         end
      end
      if (aborted) begin
         @(posedge clk); #1;
         check_outputs_zero("after_rst");
         rst = 1'b0;
      end else begin
         check_eq("write_beats_driven", driven, n);
         @(posedge clk); #1;
         check_eq("awready_pulses", aw_pulses, 1);
         check_eq("wvalid_beats", seen, n);
         check_eq("arready_during_write", ar_pulses, 0);
      end
      bus.wready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int len,
                          input int stall_beat, input int stall_len);
      int n = (len == 0) ? 1 : len;
      int got = 0, ar_pulses = 0, ar_cyc = -1, rv_cyc = -1, cyc = 0;
      int stall_left = stall_len;
      logic [DWIDTH-1:0] exp;
      for (int k = 0; k < n; k++) exp_q.push_back(model[widx(addr, k)]);
      bus.araddr  = addr;
      bus.arlen   = LWIDTH'(len);
      bus.arvalid = 1'b1;
      bus.rready  = 1'b1;
      while (got < n && cyc < 200) begin
         @(posedge clk); #1; cyc++;
         if (bus.arready) begin ar_pulses++; ar_cyc = cyc; bus.arvalid = 1'b0; end
         if (bus.rvalid && rv_cyc < 0) rv_cyc = cyc;
         if (bus.rvalid && got == stall_beat && stall_left > 0) begin
            bus.rready = 1'b0; stall_left--;
         end else begin
            bus.rready = 1'b1;
         end
         if (bus.rvalid) begin
            if (bus.rready) begin
               exp = exp_q.pop_front();
               check_eq("rdata", bus.rdata, exp);
               check_eq("rlast", bus.rlast, got == n - 1);
               got++;
            end else begin
               check_eq("rdata_hold", bus.rdata, exp_q[0]);
               check_eq("rlast_hold", bus.rlast, got == n - 1);
            end
         end
      end
      check_eq("read_beats", got, n);
      check_eq("arready_pulses", ar_pulses, 1);
      check_eq("rvalid_latency", rv_cyc, ar_cyc + 1);
      @(posedge clk); #1;
      check_eq("rvalid_after_last", bus.rvalid, 0);
      check_eq("rlast_after_last", bus.rlast, 0);
      bus.rready = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata  = '0; bus.wready = 1'b0;
      bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Two-beat write to word 4, then unaligned read of the same words.
      do_write(32'h10, 2, 32'hA1, -1, 0, -1);
      check_eq("model_word4", model[4], 32'hA1);
      check_eq("model_word5", model[5], 32'hB2);
      do_read(32'h12, 2, -1, 0);

      // Simultaneous requests at 0: write first, read sees new data.
      bus.araddr = '0; bus.arlen = 8'd1; bus.arvalid = 1'b1;
      do_write(32'h0, 1, 32'h5A5A_0001, -1, 0, -1);
      do_read(32'h0, 1, -1, 0);

      // Wrap past the last word, both directions.
      do_write((DEPTH - 1) * 4, 2, 32'h7700_00E0, -1, 0, -1);
      do_read((DEPTH - 1) * 4, 2, -1, 0);

      // Zero length moves exactly one beat.
      do_write(32'h40, 0, 32'h3C, -1, 0, -1);
      do_read(32'h40, 0, -1, 0);

      // Back-pressure in the middle of bursts.
      do_write(32'h80, 4, 32'h1000, 1, 2, -1);
      do_read(32'h80, 4, 2, 3);

      // Reset during the second beat of a two-beat write to word 8.
      do_write(32'h20, 2, 32'hC3, -1, 0, 1);
      do_read(32'h20, 2, -1, 0);
      do_write(32'h30, 3, 32'hE0, -1, 0, -1);
      do_read(32'h30, 3, -1, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
`default_nettype wire
